seven_seg_driver: RTL and testbench
===================================

SEVEN_SEG_DRIVER -- requirements
Module: seven_seg_driver

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 50000, meaning CLK cycles per digit dwell (legal range 2..2^20).
REQ-002 The module SHALL have parameter N_DIGITS, default 8, meaning digits scanned; only 8 is supported.
REQ-003 The module SHALL have port CLK  input  1  single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port HEX_IN  input  32  value to display; nibble k drives digit k, with digit 0 = HEX_IN[3:0].
REQ-006 The module SHALL have port HEX_VALID  input  1  one-cycle load strobe for HEX_IN.
REQ-007 The module SHALL have port BLANK_LZ  input  1  leading-zero blanking enable, sampled every cycle.
REQ-008 The module SHALL have port DP_IN  input  8  decimal point per digit, active high.
REQ-009 The module SHALL have port AN  output  8  digit anodes, active low, at most one bit low.
REQ-010 The module SHALL have port SEG  output  7  {g,f,e,d,c,b,a}, active low.
REQ-011 The module SHALL have port DP  output  1  decimal point, active low.
REQ-012 The module SHALL have port FRAME  output  1  one-cycle pulse at each scan wrap from digit 7 to digit 0.

Function
REQ-013 Prescaler cnt SHALL count 0..CLK_DIV-1; tick = (cnt==CLK_DIV-1), and cnt returns to 0 on tick.
REQ-014 On tick, digit index idx SHALL advance idx+1 mod 8; idx SHALL hold otherwise.
REQ-015 A HEX_VALID strobe SHALL write HEX_IN to the pending register and set pend_v; a later strobe overwrites it, so the latest value wins.
REQ-016 On tick with idx==7 and pend_v==1, pending SHALL copy to the display register disp and pend_v SHALL clear.
REQ-017 If HEX_VALID coincides with tick and idx==7, HEX_IN SHALL load directly into disp and pend_v SHALL clear.
REQ-018 disp SHALL change only at a frame wrap (REQ-016/017), so a frame never mixes two values.
REQ-019 FRAME SHALL be 1 exactly in the cycle of tick with idx==7, whether or not a load occurs.
REQ-020 AN, SEG and DP SHALL be registered; in cycle t+1 they reflect idx, disp, DP_IN and BLANK_LZ of cycle t.
REQ-021 AN SHALL be ~(8'b1 << idx).
REQ-022 SEG SHALL be the hex decode of disp nibble idx, e.g. 0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, F->7'h0E.
REQ-023 With BLANK_LZ=1, digit k>0 SHALL show SEG=7'h7F and DP=1 when nibbles k..7 of disp are all zero; digit 0 is never blanked.
REQ-024 When not blanked, DP SHALL be ~DP_IN[idx].

Reset
REQ-025 In any cycle with RESET=1: cnt=0, idx=0, disp=0, pending=0, pend_v=0, AN=8'hFF, SEG=7'h7F, DP=1, FRAME=0.
REQ-026 RESET SHALL override every simultaneous event, including a HEX_VALID or a tick.
REQ-027 A strobe in the reset cycle SHALL be discarded.
REQ-028 In the first cycle after RESET deasserts, AN SHALL be 8'hFE and SEG 7'h40.

Structure
REQ-029 Package seg_pkg SHALL hold the segment constants SEG_BLANK=7'h7F and the 16-entry hex code table, plus N_DIGITS_MAX=8.
REQ-030 Hex-to-segment decode SHALL be a combinational sub-module hex_to_seg (4-bit in, 7-bit out), instantiated once.
REQ-031 Prescaler width SHALL be $clog2(CLK_DIV).

Verification (CLK_DIV=4; one frame = 32 cycles)
REQ-032 Reset release, no load -> AN steps FE,FD,FB..7F with 4 cycles per digit, SEG=7'h40 throughout, FRAME every 32 cycles.
REQ-033 HEX_VALID with 32'h12345678 mid-frame -> disp unchanged until the next FRAME; the following frame shows digit0=8 (7'h00) through digit7=1 (7'h79).
REQ-034 Strobes of 32'hAAAAAAAA then 32'h0000000F in the same frame -> only 0000000F is displayed; AAAAAAAA never appears.
REQ-035 BLANK_LZ=1 with disp=32'h0000000F -> digit0 SEG=7'h0E; digits 1..7 SEG=7'h7F, DP=1; disp=0 -> only digit0 lit, showing 7'h40.
REQ-036 HEX_VALID on the FRAME cycle with 32'hFFFFFFFF -> the next frame shows all 7'h0E; pend_v=0 afterward.
REQ-037 RESET pulsed at idx=5 with a pending load -> next cycle all outputs at reset values; after release the display shows 0 and the pending value is lost.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment constants: blank code, hex glyph table, digit count.
package seg_pkg;
  localparam int N_DIGITS_MAX = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 15 is the MSB slice, entry 0 the LSB.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble-to-glyph decode, active-low segments.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[hex];
endmodule

// File: rtl/seven_seg_driver.sv
// Eight-digit multiplexed hex display scanner with frame-aligned value
// updates and optional leading-zero blanking.
module seven_seg_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int N_DIGITS = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] HEX_IN,
  input  logic        HEX_VALID,
  input  logic        BLANK_LZ,
  input  logic [7:0]  DP_IN,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        FRAME
);
  localparam int              CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [2:0]      LAST_IDX = 3'(N_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   disp, pending;
  logic          pend_v;
  logic          tick, wrap, blank;
  logic [31:0]   upper;
  logic [6:0]    dec_seg;

  assign tick  = (cnt == CNT_MAX);
  assign wrap  = tick && (idx == LAST_IDX);
  assign FRAME = wrap && !RESET;

  // Digit k is a leading zero when it and every more-significant nibble are 0.
  assign upper = disp >> {idx, 2'b00};
  assign blank = BLANK_LZ && (idx != 3'd0) && (upper == 32'd0);

  hex_to_seg u_dec (
    .hex (disp[{idx, 2'b00} +: 4]),
    .seg (dec_seg)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt     <= '0;
      idx     <= '0;
      disp    <= '0;
      pending <= '0;
      pend_v  <= 1'b0;
      AN      <= 8'hFF;
      SEG     <= SEG_BLANK;
      DP      <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 3'd1;

      // disp only moves at the wrap so one frame never shows two values;
      // a strobe landing exactly on the wrap bypasses the pending register.
      if (wrap) begin
        if (HEX_VALID)   disp <= HEX_IN;
        else if (pend_v) disp <= pending;
        pend_v <= 1'b0;
      end else if (HEX_VALID) begin
        pending <= HEX_IN;
        pend_v  <= 1'b1;
      end

      AN  <= ~(8'b1 << idx);
      SEG <= blank ? SEG_BLANK : dec_seg;
      DP  <= blank ? 1'b1 : ~DP_IN[idx];
    end
  end
endmodule

// File: tb/tb_seven_seg_driver.sv
// Directed + randomized bench for seven_seg_driver against a cycle-count model.
module tb_seven_seg_driver;
  localparam int CD = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] HEX_IN = '0;
  logic        HEX_VALID = 1'b0;
  logic        BLANK_LZ = 1'b0;
  logic [7:0]  DP_IN = '0;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP, FRAME;

  int checks = 0;
  int failures = 0;

  // Model: n counts clock edges since reset release; scan position follows from n.
  int          n = 0;
  logic [31:0] m_disp = '0, m_pend = '0;
  bit          m_pv = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_driver #(.CLK_DIV(CD), .N_DIGITS(8)) dut (
    .CLK(CLK), .RESET(RESET), .HEX_IN(HEX_IN), .HEX_VALID(HEX_VALID),
    .BLANK_LZ(BLANK_LZ), .DP_IN(DP_IN), .AN(AN), .SEG(SEG), .DP(DP), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    int         idx;
    bit         tick, wrap, blank;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [31:0] nib;
    idx   = (n / CD) % 8;
    tick  = (n % CD) == CD - 1;
    wrap  = tick && (idx == 7);
    chk("frame", {31'd0, FRAME}, {31'd0, wrap});
    blank = BLANK_LZ && (idx > 0) && ((m_disp >> (4 * idx)) == 0);
    e_an  = 8'd1 << idx;
    e_an  = ~e_an;
    nib   = (m_disp >> (4 * idx)) & 32'hF;
    e_seg = blank ? 7'h7F : seg_tab[nib[3:0]];
    e_dp  = blank ? 1'b1 : ~DP_IN[idx];
    @(posedge CLK); #1;
    chk("an",  {24'd0, AN},  {24'd0, e_an});
    chk("seg", {25'd0, SEG}, {25'd0, e_seg});
    chk("dp",  {31'd0, DP},  {31'd0, e_dp});
    if (wrap) begin
      if (HEX_VALID)  m_disp = HEX_IN;
      else if (m_pv)  m_disp = m_pend;
      m_pv = 1'b0;
    end else if (HEX_VALID) begin
      m_pend = HEX_IN;
      m_pv   = 1'b1;
    end
    n++;
  endtask

  task automatic rst_step();
    RESET = 1'b1;
    chk("rst_frame_pre", {31'd0, FRAME}, 32'd0);
    @(posedge CLK); #1;
    chk("rst_an",    {24'd0, AN},    32'hFF);
    chk("rst_seg",   {25'd0, SEG},   32'h7F);
    chk("rst_dp",    {31'd0, DP},    32'd1);
    chk("rst_frame", {31'd0, FRAME}, 32'd0);
    n = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
  endtask

  task automatic load(input logic [31:0] v);
    HEX_IN = v; HEX_VALID = 1'b1;
    step();
    HEX_VALID = 1'b0;
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic to_phase(input int p);
    while ((n % 32) != p) step();
  endtask

  initial begin
    // Reset, with a strobe inside the reset window that must be dropped.
    rst_step();
    HEX_IN = 32'hDEADBEEF; HEX_VALID = 1'b1;
    rst_step();
    HEX_VALID = 1'b0;
    rst_step();
    RESET = 1'b0;

    step();
    chk("release_an",  {24'd0, AN},  32'hFE);
    chk("release_seg", {25'd0, SEG}, 32'h40);
    run(63);

    // Mid-frame load appears only after the next wrap.
    to_phase(12); load(32'h12345678); run(80);

    // Latest of two strobes in one frame wins.
    to_phase(5); load(32'hAAAAAAAA); run(6); load(32'h0000000F); run(70);

    // Leading-zero blanking, then all-zero value.
    BLANK_LZ = 1'b1; run(40);
    to_phase(3); load(32'h0); run(70);

    // Strobe exactly on the wrap cycle loads directly.
    BLANK_LZ = 1'b0; DP_IN = 8'hA5;
    to_phase(31); load(32'hFFFFFFFF); run(70);

    // Reset at digit 5 with a load pending: pending value is lost.
    to_phase(8); load(32'h13572468);
    to_phase(21); rst_step(); RESET = 1'b0;
    run(70);

    repeat (600) begin
      BLANK_LZ  = 1'($urandom_range(0, 1));
      DP_IN     = 8'($urandom);
      HEX_IN    = $urandom >> $urandom_range(0, 31);
      HEX_VALID = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 249) == 0) begin
        rst_step(); RESET = 1'b0;
      end else begin
        step();
      end
      HEX_VALID = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
